// File: rtl/d_branch_pred_cmp_pkg.sv
// Shared encodings for the D-stage branch resolver: branch type codes and
// 2-bit predictor counter states, plus the counter step helper.
package d_branch_pred_cmp_pkg;

  localparam logic [2:0] B_NONE = 3'd0;
  localparam logic [2:0] B_BEQ  = 3'd1;
  localparam logic [2:0] B_BNE  = 3'd2;
  localparam logic [2:0] B_BLEZ = 3'd3;
  localparam logic [2:0] B_BGEZ = 3'd4;
  localparam logic [2:0] B_BGTZ = 3'd5;
  localparam logic [2:0] B_BLTZ = 3'd6;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  localparam logic [1:0] COUNTER_RESET = WNT;

  // Saturating step: dir=1 moves toward strongly taken, dir=0 toward strongly not-taken.
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic dir);
    if (dir) return (c == ST) ? ST : c + 2'd1;
    else     return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/d_branch_pred_cmp_sat_counter.sv
// One 2-bit saturating predictor counter; the BHT is an array of these.
module bp_sat_counter
  import d_branch_pred_cmp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  output logic [1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  cnt <= COUNTER_RESET;
    else if (en) cnt <= sat_step(cnt, dir);
  end

endmodule

// File: rtl/d_branch_pred_cmp.sv
// D-stage branch resolver with a PC-indexed 2-bit BHT, mispredict flag and
// saturating perf counters for resolved branches and mispredictions.
module d_branch_pred_cmp
  import d_branch_pred_cmp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 64,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  f_pc,
  output logic              f_pred_taken,
  input  logic              d_valid,
  input  logic              d_stall,
  input  logic [WIDTH-1:0]  d_pc,
  input  logic [2:0]        d_type,
  input  logic [WIDTH-1:0]  d_rs,
  input  logic [WIDTH-1:0]  d_rt,
  input  logic              d_pred_taken,
  output logic              b_jump,
  output logic              mispredict,
  input  logic              clr_stats,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mis_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_ONE;
  endfunction

  logic signed [WIDTH-1:0] rs_s;
  logic                    eq, z, neg, cond, is_br, upd;
  logic [IDX_W-1:0]        f_idx, d_idx;
  logic [1:0]              cnt [BHT_DEPTH];
  logic [BHT_DEPTH-1:0]    en;
  logic                    unused_pc_bits;

  assign rs_s  = d_rs;
  assign eq    = (d_rs == d_rt);
  assign z     = (d_rs == '0);
  assign neg   = rs_s[WIDTH-1];
  assign is_br = d_valid && (d_type != B_NONE) && (d_type != 3'd7);

  always_comb begin
    cond = 1'b0;
    case (d_type)
      B_BEQ:   cond = eq;
      B_BNE:   cond = !eq;
      B_BLEZ:  cond = neg || z;
      B_BGEZ:  cond = !neg;
      B_BGTZ:  cond = !neg && !z;
      B_BLTZ:  cond = neg;
      default: cond = 1'b0;
    endcase
  end

  assign b_jump     = is_br && cond;
  assign mispredict = is_br && (b_jump != d_pred_taken);
  assign upd        = is_br && !d_stall;

  // Word-aligned PCs: bits [1:0] never select an entry; no tag, so aliasing is expected.
  assign f_idx = f_pc[IDX_W+1:2];
  assign d_idx = d_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{f_pc[WIDTH-1:IDX_W+2], f_pc[1:0], d_pc[WIDTH-1:IDX_W+2], d_pc[1:0]};

  for (genvar i = 0; i < BHT_DEPTH; i++) begin : g_bht
    assign en[i] = upd && (d_idx == IDX_W'(i));
    bp_sat_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (en[i]),
      .dir   (b_jump),
      .cnt   (cnt[i])
    );
  end

  // Lookup reads registered counters only, so a same-cycle write is not bypassed.
  assign f_pred_taken = cnt[f_idx][1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_count  <= '0;
      mis_count <= '0;
    end else if (clr_stats) begin
      br_count  <= '0;
      mis_count <= '0;
    end else if (upd) begin
      br_count <= sat_inc(br_count);
      if (mispredict) mis_count <= sat_inc(mis_count);
    end
  end

endmodule

// File: tb/tb_d_branch_pred_cmp.sv
// Directed bench for d_branch_pred_cmp: expected values are queued as stimulus
// is applied and popped against DUT outputs at each sample point.
module tb_d_branch_pred_cmp;
  import d_branch_pred_cmp_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] f_pc = '0;
  logic        d_valid = 1'b0, d_stall = 1'b0, d_pred_taken = 1'b0, clr_stats = 1'b0;
  logic [31:0] d_pc = '0, d_rs = '0, d_rt = '0;
  logic [2:0]  d_type = '0;
  logic        f_pred_taken, b_jump, mispredict;
  logic [31:0] br_count, mis_count;
  logic        f_pred_taken4, b_jump4, mispredict4;
  logic [3:0]  br_count4, mis_count4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  d_branch_pred_cmp dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .d_valid(d_valid), .d_stall(d_stall), .d_pc(d_pc), .d_type(d_type),
    .d_rs(d_rs), .d_rt(d_rt), .d_pred_taken(d_pred_taken),
    .b_jump(b_jump), .mispredict(mispredict), .clr_stats(clr_stats),
    .br_count(br_count), .mis_count(mis_count)
  );

  d_branch_pred_cmp #(.STAT_W(4)) dut4 (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken4),
    .d_valid(d_valid), .d_stall(d_stall), .d_pc(d_pc), .d_type(d_type),
    .d_rs(d_rs), .d_rt(d_rt), .d_pred_taken(d_pred_taken),
    .b_jump(b_jump4), .mispredict(mispredict4), .clr_stats(clr_stats),
    .br_count(br_count4), .mis_count(mis_count4)
  );

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return {31'b0, f_pred_taken};
      1: return {31'b0, b_jump};
      2: return {31'b0, mispredict};
      3: return br_count;
      4: return mis_count;
      5: return {28'b0, br_count4};
      6: return {28'b0, mis_count4};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      n_assert++;
      assert (o === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic chk_pred(input logic [31:0] pc, input logic exp, input string tag);
    f_pc = pc;
    #1;
    push(tag, 0, {31'b0, exp});
    drain();
  endtask

  task automatic chk_stats(input logic [31:0] br, input logic [31:0] mis, input string tag);
    push({tag, "_br"}, 3, br);
    push({tag, "_mis"}, 4, mis);
    drain();
  endtask

  // Presents one D-stage instruction for a single edge, checking the combinational outcome.
  task automatic branch(input logic [2:0] ty, input logic [31:0] pc, input logic [31:0] rs,
                        input logic [31:0] rt, input logic pred, input logic stall,
                        input logic exp_j, input logic exp_m, input string tag);
    @(negedge clk);
    d_valid = 1'b1; d_type = ty; d_pc = pc; d_rs = rs; d_rt = rt;
    d_pred_taken = pred; d_stall = stall;
    #1;
    push({tag, "_jump"}, 1, {31'b0, exp_j});
    push({tag, "_mis"}, 2, {31'b0, exp_m});
    drain();
    @(posedge clk);
    #1;
    d_valid = 1'b0; d_stall = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    push("rst_pred", 0, 32'd0);
    push("rst_br", 3, 32'd0);
    push("rst_mis", 4, 32'd0);
    push("rst_jump", 1, 32'd0);
    drain();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 64; i++) chk_pred(32'h3000 + 32'(i) * 4, 1'b0, "init_pred");
    chk_stats(0, 0, "init");

    // Training walk on index 0: 01 -> 10 -> 11 -> 11 -> 10 -> 01
    branch(B_BEQ, 32'h3000, 5, 5, 1'b0, 1'b0, 1'b1, 1'b1, "beq1");
    chk_pred(32'h3000, 1'b1, "pred_after1");
    chk_stats(1, 1, "after1");
    branch(B_BEQ, 32'h3000, 5, 5, 1'b1, 1'b0, 1'b1, 1'b0, "beq2");
    branch(B_BEQ, 32'h3000, 5, 5, 1'b1, 1'b0, 1'b1, 1'b0, "beq3");
    chk_pred(32'h3000, 1'b1, "pred_sat");
    branch(B_BEQ, 32'h3000, 5, 6, 1'b1, 1'b0, 1'b0, 1'b1, "beq_nt1");
    chk_pred(32'h3000, 1'b1, "pred_after_nt1");
    branch(B_BEQ, 32'h3000, 5, 6, 1'b1, 1'b0, 1'b0, 1'b1, "beq_nt2");
    chk_pred(32'h3000, 1'b0, "pred_after_nt2");
    chk_stats(5, 3, "walk");

    // Signed edges, held stalled so nothing trains
    branch(B_BLEZ, 32'h3080, 32'h8000_0000, 0, 1'b0, 1'b1, 1'b1, 1'b1, "blez_neg");
    branch(B_BLTZ, 32'h3080, 32'h8000_0000, 0, 1'b0, 1'b1, 1'b1, 1'b1, "bltz_neg");
    branch(B_BGEZ, 32'h3080, 32'h8000_0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, "bgez_neg");
    branch(B_BGTZ, 32'h3080, 32'h8000_0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, "bgtz_neg");
    branch(B_BLEZ, 32'h3080, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, "blez_zero");
    branch(B_BGEZ, 32'h3080, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, "bgez_zero");
    branch(B_BGTZ, 32'h3080, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "bgtz_zero");
    branch(B_BLTZ, 32'h3080, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "bltz_zero");
    branch(B_BGTZ, 32'h3080, 1, 0, 1'b0, 1'b1, 1'b1, 1'b1, "bgtz_one");
    branch(B_BGEZ, 32'h3080, 1, 0, 1'b0, 1'b1, 1'b1, 1'b1, "bgez_one");
    branch(B_BLEZ, 32'h3080, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, "blez_one");
    branch(B_BNE, 32'h3080, 1, 2, 1'b0, 1'b1, 1'b1, 1'b1, "bne_diff");
    branch(B_BEQ, 32'h3080, 1, 2, 1'b0, 1'b1, 1'b0, 1'b0, "beq_diff");
    branch(3'd7, 32'h3080, 3, 3, 1'b1, 1'b1, 1'b0, 1'b0, "type7");
    branch(B_NONE, 32'h3080, 3, 3, 1'b1, 1'b1, 1'b0, 1'b0, "type0");
    chk_pred(32'h3080, 1'b0, "stalled_untrained");
    chk_stats(5, 3, "stalled_nostat");

    // Aliasing: 0x3100 shares index 0 with 0x3000
    branch(B_BEQ, 32'h3000, 9, 9, 1'b0, 1'b0, 1'b1, 1'b1, "alias_train");
    chk_pred(32'h3100, 1'b1, "alias_pred");
    chk_pred(32'h3004, 1'b0, "neighbor_pred");
    chk_stats(6, 4, "alias");

    @(negedge clk) clr_stats = 1'b1;
    @(posedge clk) #1 clr_stats = 1'b0;
    chk_stats(0, 0, "clr");

    // Stalled branch held for three edges, trained once on release
    @(negedge clk);
    d_valid = 1'b1; d_type = B_BNE; d_pc = 32'h3008; d_rs = 1; d_rt = 2;
    d_pred_taken = 1'b0; d_stall = 1'b1; f_pc = 32'h3008;
    repeat (3) begin
      #1;
      push("stall_jump", 1, 32'd1);
      push("stall_mis", 2, 32'd1);
      push("stall_pred", 0, 32'd0);
      push("stall_br", 3, 32'd0);
      push("stall_misc", 4, 32'd0);
      drain();
      @(negedge clk);
    end
    d_stall = 1'b0;
    @(posedge clk) #1 d_valid = 1'b0;
    chk_pred(32'h3008, 1'b1, "stall_release_pred");
    chk_stats(1, 1, "stall_release");
    @(posedge clk) #1;
    chk_stats(1, 1, "stall_hold");

    // Clear coinciding with a mispredicting branch
    @(negedge clk);
    d_valid = 1'b1; d_type = B_BEQ; d_pc = 32'h300C; d_rs = 7; d_rt = 7;
    d_pred_taken = 1'b0; clr_stats = 1'b1;
    #1;
    push("clr_mis_flag", 2, 32'd1);
    drain();
    @(posedge clk) #1;
    d_valid = 1'b0; clr_stats = 1'b0;
    chk_stats(0, 0, "clr_prio");
    chk_pred(32'h300C, 1'b1, "clr_trained");

    // Perf counter saturation on the 4-bit build
    for (int i = 0; i < 15; i++)
      branch(B_BEQ, 32'h3010, 4, 4, 1'b0, 1'b0, 1'b1, 1'b1, "sat_run");
    push("sat15_br4", 5, 32'd15);
    push("sat15_mis4", 6, 32'd15);
    drain();
    for (int i = 0; i < 2; i++)
      branch(B_BEQ, 32'h3010, 4, 4, 1'b0, 1'b0, 1'b1, 1'b1, "sat_over");
    push("sat_br4", 5, 32'd15);
    push("sat_mis4", 6, 32'd15);
    drain();
    chk_stats(17, 17, "wide");
    chk_pred(32'h3010, 1'b1, "sat_pred");

    // Asynchronous reset pulse in the middle of the high phase
    @(posedge clk) #2 reset = 1'b0;
    #1;
    push("async_pred", 0, 32'd0);
    push("async_br", 3, 32'd0);
    push("async_mis", 4, 32'd0);
    push("async_br4", 5, 32'd0);
    push("async_jump", 1, 32'd0);
    drain();
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
    chk_pred(32'h3010, 1'b0, "post_rst_pred");
    chk_pred(32'h3000, 1'b0, "post_rst_pred0");
    chk_stats(0, 0, "post_rst");
    branch(B_BGEZ, 32'h3000, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, "post_rst_br");
    chk_pred(32'h3000, 1'b1, "post_rst_train");
    chk_stats(1, 1, "post_rst_cnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
